// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage and the external ALU:
// opcode values, instruction field positions, FSM state encodings
// and small decode helpers.
package exec_stage_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  // Opcodes; 000 doubles as the "no operation" value on alu_op.
  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_ILL1   = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_SHIFTL = 3'b100;
  localparam logic [2:0] OP_SHIFTR = 3'b101;
  localparam logic [2:0] OP_ADDI   = 3'b110;
  localparam logic [2:0] OP_SUBI   = 3'b111;

  // Instruction word field positions.
  localparam int F_OPC_HI = 31;
  localparam int F_OPC_LO = 29;
  localparam int F_RD_HI  = 28;
  localparam int F_RD_LO  = 26;
  localparam int F_RS1_HI = 25;
  localparam int F_RS1_LO = 23;
  localparam int F_RS2_HI = 22;
  localparam int F_RS2_LO = 20;
  localparam int F_IMM_HI = 19;
  localparam int F_IMM_LO = 0;
  localparam int IMM_W    = F_IMM_HI - F_IMM_LO + 1;

  // FSM state encodings.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       rd;
    logic [2:0]       rs1;
    logic [2:0]       rs2;
    logic [IMM_W-1:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [DATA_W-1:0] w);
    instr_t d;
    d.opcode = w[F_OPC_HI:F_OPC_LO];
    d.rd     = w[F_RD_HI:F_RD_LO];
    d.rs1    = w[F_RS1_HI:F_RS1_LO];
    d.rs2    = w[F_RS2_HI:F_RS2_LO];
    d.imm    = w[F_IMM_HI:F_IMM_LO];
    return d;
  endfunction

  // Only 000 and 001 are undefined.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op != OP_NONE) && (op != OP_ILL1);
  endfunction

  // ADDI/SUBI take a zero-extended immediate as the second operand.
  function automatic logic uses_imm(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/exec_stage_regfile.sv
// 8 x 32 register file: two combinational read ports, one debug read
// port and one synchronous write port. r0 is hardwired to zero.
module regfile
  import exec_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [REG_AW-1:0]   i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [REG_AW-1:0]   i_raddr1,
  output logic [DATA_W-1:0]   o_rdata1,
  input  logic [REG_AW-1:0]   i_raddr2,
  output logic [DATA_W-1:0]   o_rdata2,
  input  logic [REG_AW-1:0]   i_dbg_addr,
  output logic [DATA_W-1:0]   o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NREG];

  // Storage: reset clears everything and wins over a same-edge write;
  // writes aimed at r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1   = (i_raddr1   == '0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2   = (i_raddr2   == '0) ? '0 : r_mem[i_raddr2];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/exec_stage.sv
// Multi-cycle execute stage: accepts one instruction at a time, reads
// operands from the local register file, drives an external ALU for one
// cycle and writes the captured result back.
// Sequence: IDLE -> READ -> EXEC -> WB -> IDLE, or IDLE -> ERR -> IDLE.
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [2:0]  alu_op,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic        err,
  output logic [2:0]  wb_addr,
  output logic [31:0] wb_data,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [DATA_W-1:0] r_result;
  instr_t            w_dec;
  logic              w_accept;
  logic              w_in_legal;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [DATA_W-1:0] w_op2_sel;

  assign w_dec      = decode_instr(r_instr);
  assign w_in_legal = is_legal_op(instr[F_OPC_HI:F_OPC_LO]);
  assign w_accept   = instr_valid && instr_ready;
  assign w_we       = (r_state == ST_WB);
  assign w_op2_sel  = uses_imm(w_dec.opcode) ? {{(DATA_W-IMM_W){1'b0}}, w_dec.imm}
                                             : w_rdata2;

  regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (w_dec.rd),
    .i_wdata    (r_result),
    .i_raddr1   (w_dec.rs1),
    .o_rdata1   (w_rdata1),
    .i_raddr2   (w_dec.rs2),
    .o_rdata2   (w_rdata2),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Next-state logic; illegal opcodes divert to ERR straight from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_in_legal ? ST_READ : ST_ERR;
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Instruction register, loaded on accept only.
  always_ff @(posedge clk) begin
    if (rst)           r_instr <= '0;
    else if (w_accept) r_instr <= instr;
  end

  // Operand latch during READ; these also hold operand1/operand2 steady
  // outside EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1 <= '0;
      r_op2 <= '0;
    end else if (r_state == ST_READ) begin
      r_op1 <= w_rdata1;
      r_op2 <= w_op2_sel;
    end
  end

  // Capture of the external ALU result at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst)                     r_result <= '0;
    else if (r_state == ST_EXEC) r_result <= alu_result;
  end

  // Outputs are forced to zero while rst is high, even before the
  // reset edge has landed in the registers.
  assign instr_ready = (r_state == ST_IDLE) && !rst;
  assign alu_op      = ((r_state == ST_EXEC) && !rst) ? w_dec.opcode : OP_NONE;
  assign operand1    = rst ? '0 : r_op1;
  assign operand2    = rst ? '0 : r_op2;
  assign done        = (r_state == ST_WB)  && !rst;
  assign err         = (r_state == ST_ERR) && !rst;
  assign wb_addr     = done ? w_dec.rd : 3'd0;
  assign wb_data     = done ? r_result : '0;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage with a behavioural external ALU,
// a register-file reference model and a writeback scoreboard.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [2:0]  alu_op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [31:0] alu_result;
  logic        done;
  logic        err;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #10 clk = ~clk;

  exec_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .operand1    (operand1),
    .operand2    (operand2),
    .alu_result  (alu_result),
    .done        (done),
    .err         (err),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  function automatic logic [31:0] alu_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'b010, 3'b110: return a + b;
      3'b011, 3'b111: return a - b;
      3'b100:         return (b >= 32) ? 32'd0 : (a << b[4:0]);
      3'b101:         return (b >= 32) ? 32'd0 : (a >> b[4:0]);
      default:        return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_op, operand1, operand2);

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [19:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  typedef struct {
    bit          is_err;
    logic [2:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rd;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m [8];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: EXEC operands and writeback/err pulses against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_op != 3'b000 && sb.size() > 0) begin
        chk("exec_op",  32'(alu_op),   32'(sb[0].opc));
        chk("exec_a",   operand1,      sb[0].a);
        chk("exec_b",   operand2,      sb[0].b);
        chk("exec_lat", 32'(cyc - sb[0].acc), 32'd2);
      end
      if (done || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("err_flag",  32'(err),  32'(mon_e.is_err));
          chk("done_flag", 32'(done), 32'(!mon_e.is_err));
          if (done) begin
            chk("wb_addr",  32'(wb_addr), 32'(mon_e.rd));
            chk("wb_data",  wb_data,      mon_e.data);
            chk("done_lat", 32'(cyc - mon_e.acc), 32'd3);
          end else begin
            chk("err_lat",  32'(cyc - mon_e.acc), 32'd1);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] ins);
    exp_t x;
    int   k;
    bit   legal;
    logic [2:0] op;
    op    = ins[31:29];
    legal = (op >= 3'b010);
    wait_ready();
    x.is_err = !legal;
    x.opc    = op;
    x.rd     = ins[28:26];
    x.a      = m[ins[25:23]];
    x.b      = (op == 3'b110 || op == 3'b111) ? {12'd0, ins[19:0]} : m[ins[22:20]];
    x.data   = alu_model(op, x.a, x.b);
    x.acc    = cyc;
    sb.push_back(x);
    if (legal && x.rd != 3'd0) m[x.rd] = x.data;
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!instr_ready && k < 12);
    chk("ready_lat", 32'(k), legal ? 32'd4 : 32'd2);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("reg_r%0d", i), dbg_data, m[i]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"},  32'(instr_ready), 32'd0);
    chk({tag, "_aluop"},  32'(alu_op),      32'd0);
    chk({tag, "_opnd1"},  operand1,         32'd0);
    chk({tag, "_opnd2"},  operand2,         32'd0);
    chk({tag, "_done"},   32'(done),        32'd0);
    chk({tag, "_err"},    32'(err),         32'd0);
    chk({tag, "_wbaddr"}, 32'(wb_addr),     32'd0);
    chk({tag, "_wbdata"}, wb_data,          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int accepts;
    for (int i = 0; i < 8; i++) m[i] = 32'd0;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(instr_ready), 32'd1);
    check_regs();

    // ADDI r1,r0,5 ; ADDI r2,r0,7
    send(mk(3'b110, 3'd1, 3'd0, 3'd0, 20'd5));
    send(mk(3'b110, 3'd2, 3'd0, 3'd0, 20'd7));
    dbg_addr = 3'd2; #1 chk("dbg_r2", dbg_data, 32'd7);
    // SUB r3,r1,r2 -> 5-7
    send(mk(3'b011, 3'd3, 3'd1, 3'd2, 20'd0));
    dbg_addr = 3'd3; #1 chk("dbg_r3", dbg_data, 32'hFFFF_FFFE);
    // ADDI r5,r0,33 ; SHIFTL r4,r1,r5 ; SHIFTR r4,r2,r0
    send(mk(3'b110, 3'd5, 3'd0, 3'd0, 20'd33));
    send(mk(3'b100, 3'd4, 3'd1, 3'd5, 20'd0));
    dbg_addr = 3'd4; #1 chk("dbg_r4_shl", dbg_data, 32'd0);
    send(mk(3'b101, 3'd4, 3'd2, 3'd0, 20'd0));
    dbg_addr = 3'd4; #1 chk("dbg_r4_shr", dbg_data, 32'd7);
    // SUBI r6,r3,2 and ADD r7,r6,r1 exercise wrap-around and dependency
    send(mk(3'b111, 3'd6, 3'd3, 3'd0, 20'd2));
    send(mk(3'b010, 3'd7, 3'd6, 3'd1, 20'd0));
    // ADDI r0,r0,9 -> write discarded
    send(mk(3'b110, 3'd0, 3'd0, 3'd0, 20'd9));
    dbg_addr = 3'd0; #1 chk("dbg_r0", dbg_data, 32'd0);
    // Illegal opcodes 001 and 000
    send(mk(3'b001, 3'd1, 3'd2, 3'd3, 20'hABCDE));
    send(mk(3'b000, 3'd2, 3'd1, 3'd1, 20'd1));
    check_regs();

    // Reset during EXEC of ADDI r6,r0,1
    wait_ready();
    instr = mk(3'b110, 3'd6, 3'd0, 3'd0, 20'd1);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_exec_op", 32'(alu_op), 32'b110);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 32'd0;
    @(negedge clk);
    chk("ready_after_abort", 32'(instr_ready), 32'd1);
    check_regs();

    // instr_valid held high across the busy cycles -> one accept
    instr = mk(3'b110, 3'd7, 3'd0, 3'd0, 20'd3);
    begin
      exp_t x;
      x.is_err = 1'b0; x.opc = 3'b110; x.rd = 3'd7;
      x.a = 32'd0; x.b = 32'd3; x.data = 32'd3; x.acc = cyc;
      sb.push_back(x);
      m[7] = 32'd3;
    end
    instr_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      if (instr_ready) accepts++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("held_accepts", 32'(accepts), 32'd1);
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    check_regs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
